mem_arbiter: RTL and testbench

//  Shares the single core memory port between instruction fetch (IFU) and load/store unit (LSU).

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the core's single memory port between the instruction
// fetch unit (IFU) and the load/store unit (LSU).
// The LSU normally wins arbitration. The IFU is forced through after
// STARVE_LIMIT LSU completions that happened while it was waiting.
// Locked LSU responses keep the grant for a follow-on access.
// A transaction that stays busy for TIMEOUT_CYCLES cycles without a response
// is aborted.
module mem_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    // instruction fetch side
    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,
    // load/store side
    input  logic        lsu_reqValid,
    input  logic        lsu_lock,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_wen,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,
    // memory port
    output logic        mem_reqValid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_wen,
    output logic [3:0]  mem_wmask,
    input  logic        mem_respValid,
    input  logic [31:0] mem_rdata,
    output logic        bus_timeout
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_BUSY_IFU = 2'd1;
    localparam logic [1:0] S_BUSY_LSU = 2'd2;

    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam bit          TMO_EN     = (TIMEOUT_CYCLES > 0);

    logic [1:0]  state, state_nxt;
    logic [3:0]  starve_cnt, starve_nxt;
    logic [31:0] tmo_cnt, tmo_nxt;

    logic busy;
    logic ifu_forced;
    logic own_ifu, own_lsu;
    logic req_act;
    logic tmo_hit;
    logic resp_ok;
    logic done;
    logic locked_resp;

    // Saturating increment of the starvation counter.
    function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
        if (cnt >= STARVE_MAX) begin
            return STARVE_MAX;
        end
        return cnt + 4'd1;
    endfunction

    // Select the owner for this cycle and classify how the cycle ends.
    always_comb begin
        busy       = (state != S_IDLE);
        ifu_forced = ifu_reqValid && (starve_cnt == STARVE_MAX);
        own_ifu    = 1'b0;
        own_lsu    = 1'b0;
        req_act    = 1'b0;
        case (state)
            S_BUSY_IFU: begin
                own_ifu = 1'b1;
                req_act = ifu_reqValid;
            end
            S_BUSY_LSU: begin
                own_lsu = 1'b1;
                req_act = lsu_reqValid;
            end
            default: begin
                own_lsu = lsu_reqValid && !ifu_forced;
                own_ifu = !own_lsu && ifu_reqValid;
                req_act = own_lsu || own_ifu;
            end
        endcase
        // A real response in the same cycle takes priority over the abort.
        tmo_hit     = TMO_EN && busy && !mem_respValid && (tmo_cnt == TMO_LAST);
        // In IDLE a response only counts if a request is going out with it.
        resp_ok     = mem_respValid && (busy || req_act);
        done        = resp_ok || tmo_hit;
        locked_resp = resp_ok && own_lsu && lsu_lock;
    end

    // Next state, starvation and timeout counter values.
    always_comb begin
        state_nxt = state;
        if (tmo_hit) begin
            state_nxt = S_IDLE;
        end else if (resp_ok) begin
            state_nxt = locked_resp ? S_BUSY_LSU : S_IDLE;
        end else if (!busy && req_act) begin
            state_nxt = own_lsu ? S_BUSY_LSU : S_BUSY_IFU;
        end

        starve_nxt = starve_cnt;
        if (done && !locked_resp) begin
            if (own_lsu && ifu_reqValid) begin
                starve_nxt = starve_inc(starve_cnt);
            end else begin
                starve_nxt = 4'd0;
            end
        end

        tmo_nxt = (busy && !mem_respValid && !tmo_hit) ? (tmo_cnt + 32'd1) : 32'd0;
    end

    // Drive the memory port from the owner and route responses back; all
    // outputs are held low while reset is asserted.
    always_comb begin
        mem_reqValid  = 1'b0;
        mem_addr      = 32'd0;
        mem_wdata     = 32'd0;
        mem_size      = 2'b00;
        mem_wen       = 1'b0;
        mem_wmask     = 4'd0;
        ifu_respValid = 1'b0;
        lsu_respValid = 1'b0;
        ifu_rdata     = 32'd0;
        lsu_rdata     = 32'd0;
        bus_timeout   = 1'b0;
        if (!reset) begin
            mem_reqValid = req_act && !tmo_hit;
            if (own_lsu) begin
                mem_addr  = lsu_addr;
                mem_wdata = lsu_wdata;
                mem_size  = lsu_size;
                mem_wen   = lsu_wen;
                mem_wmask = lsu_wmask;
            end else if (own_ifu) begin
                mem_addr  = ifu_addr;
                mem_wdata = 32'd0;
                mem_size  = 2'b10;
                mem_wen   = 1'b0;
                mem_wmask = 4'b1111;
            end
            ifu_respValid = done && own_ifu;
            lsu_respValid = done && own_lsu;
            ifu_rdata     = mem_rdata;
            lsu_rdata     = mem_rdata;
            bus_timeout   = tmo_hit;
        end
    end

    // State and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            starve_cnt <= 4'd0;
            tmo_cnt    <= 32'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            tmo_cnt    <= tmo_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run of mem_arbiter
// against a transaction-level reference model of the arbitration rules.
module tb_mem_arbiter;

    localparam int SL  = 2;
    localparam int TMO = 8;

    logic        clock;
    logic        reset;
    logic        ifu_reqValid;
    logic [31:0] ifu_addr;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    logic        lsu_reqValid;
    logic        lsu_lock;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [1:0]  lsu_size;
    logic        lsu_wen;
    logic [3:0]  lsu_wmask;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        mem_reqValid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_wen;
    logic [3:0]  mem_wmask;
    logic        mem_respValid;
    logic [31:0] mem_rdata;
    logic        bus_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(
        .STARVE_LIMIT  (SL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ifu_reqValid (ifu_reqValid),
        .ifu_addr     (ifu_addr),
        .ifu_respValid(ifu_respValid),
        .ifu_rdata    (ifu_rdata),
        .lsu_reqValid (lsu_reqValid),
        .lsu_lock     (lsu_lock),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .lsu_size     (lsu_size),
        .lsu_wen      (lsu_wen),
        .lsu_wmask    (lsu_wmask),
        .lsu_respValid(lsu_respValid),
        .lsu_rdata    (lsu_rdata),
        .mem_reqValid (mem_reqValid),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_size     (mem_size),
        .mem_wen      (mem_wen),
        .mem_wmask    (mem_wmask),
        .mem_respValid(mem_respValid),
        .mem_rdata    (mem_rdata),
        .bus_timeout  (bus_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        ifu_reqValid  = 1'b0;
        ifu_addr      = 32'd0;
        lsu_reqValid  = 1'b0;
        lsu_lock      = 1'b0;
        lsu_addr      = 32'd0;
        lsu_wdata     = 32'd0;
        lsu_size      = 2'b10;
        lsu_wen       = 1'b0;
        lsu_wmask     = 4'hF;
        mem_respValid = 1'b0;
        mem_rdata     = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic new_lsu();
        lsu_addr  = $urandom;
        lsu_wdata = $urandom;
        lsu_size  = 2'($urandom_range(0, 2));
        lsu_wen   = 1'($urandom_range(0, 1));
        lsu_wmask = 4'($urandom_range(0, 15));
        lsu_lock  = ($urandom_range(0, 99) < 25);
    endtask

    // Reference model: who holds the port (0 none, 1 IFU, 2 LSU), the
    // LSU-over-waiting-IFU tally, and how long the current holder has waited.
    int m_owner, m_starve, m_wait;
    int who;
    bit want, timeout, finished, locked, e_mreq;
    bit p_ifu_done, p_lsu_done, p_lsu_locked;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_size;
    logic        e_wen;
    logic [3:0]  e_wmask;

    initial begin
        reset = 1'b1;
        idle_inputs();

        // Outputs held low during reset even with every input active.
        ifu_reqValid  = 1'b1;
        lsu_reqValid  = 1'b1;
        lsu_addr      = 32'h1234_5678;
        mem_respValid = 1'b1;
        mem_rdata     = 32'hDEAD_BEEF;
        #1;
        check_val("rst_mem_req", 32'(mem_reqValid), 0);
        check_val("rst_ifu_resp", 32'(ifu_respValid), 0);
        check_val("rst_lsu_resp", 32'(lsu_respValid), 0);
        check_val("rst_tmo", 32'(bus_timeout), 0);
        check_val("rst_rdata", ifu_rdata, 0);
        check_val("rst_addr", mem_addr, 0);
        do_reset();

        // IFU alone, response in the same cycle.
        ifu_reqValid  = 1'b1;
        ifu_addr      = 32'h8000_0000;
        mem_respValid = 1'b1;
        mem_rdata     = 32'h0000_0013;
        #1;
        check_val("ifu0_req", 32'(mem_reqValid), 1);
        check_val("ifu0_addr", mem_addr, 32'h8000_0000);
        check_val("ifu0_size", 32'(mem_size), 2);
        check_val("ifu0_wmask", 32'(mem_wmask), 4'hF);
        check_val("ifu0_resp", 32'(ifu_respValid), 1);
        check_val("ifu0_lsuresp", 32'(lsu_respValid), 0);
        check_val("ifu0_rdata", ifu_rdata, 32'h0000_0013);
        @(negedge clock);
        idle_inputs();
        #1;
        check_val("ifu0_idle", 32'(dut.state), 0);

        // Both request, memory latency 2: LSU first, IFU afterwards.
        do_reset();
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h8000_0040;
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h0000_2000;
        lsu_wen      = 1'b1;
        lsu_wdata    = 32'hCAFE_0001;
        #1;
        check_val("both_addr0", mem_addr, 32'h0000_2000);
        check_val("both_wen0", 32'(mem_wen), 1);
        @(negedge clock);
        #1;
        check_val("both_addr1", mem_addr, 32'h0000_2000);
        check_val("both_noresp", 32'(ifu_respValid | lsu_respValid), 0);
        @(negedge clock);
        mem_respValid = 1'b1;
        mem_rdata     = 32'h5555_AAAA;
        #1;
        check_val("both_lsuresp", 32'(lsu_respValid), 1);
        check_val("both_ifuresp", 32'(ifu_respValid), 0);
        check_val("both_lsurdata", lsu_rdata, 32'h5555_AAAA);
        @(negedge clock);
        lsu_reqValid  = 1'b0;
        mem_respValid = 1'b0;
        #1;
        check_val("both_ifugrant", mem_addr, 32'h8000_0040);
        check_val("both_ifureq", 32'(mem_reqValid), 1);
        check_val("both_starve", 32'(dut.starve_cnt), 1);

        // Starvation limit 2: LSU, LSU, then IFU forced through.
        do_reset();
        ifu_reqValid  = 1'b1;
        ifu_addr      = 32'h8000_0100;
        lsu_reqValid  = 1'b1;
        lsu_addr      = 32'h0000_3000;
        mem_respValid = 1'b1;
        #1;
        check_val("stv_g1", mem_addr, 32'h0000_3000);
        check_val("stv_r1", 32'(lsu_respValid), 1);
        @(negedge clock);
        lsu_addr = 32'h0000_3004;
        #1;
        check_val("stv_g2", mem_addr, 32'h0000_3004);
        check_val("stv_r2", 32'(lsu_respValid), 1);
        @(negedge clock);
        lsu_addr = 32'h0000_3008;
        #1;
        check_val("stv_g3", mem_addr, 32'h8000_0100);
        check_val("stv_r3", 32'(ifu_respValid), 1);
        check_val("stv_r3l", 32'(lsu_respValid), 0);
        @(negedge clock);
        ifu_reqValid = 1'b0;
        #1;
        check_val("stv_cnt0", 32'(dut.starve_cnt), 0);
        check_val("stv_g4", mem_addr, 32'h0000_3008);

        // Locked misaligned LSU pair keeps the port away from a pending IFU.
        do_reset();
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h8000_0200;
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h0000_1001;
        lsu_lock     = 1'b1;
        #1;
        check_val("lck_a0", mem_addr, 32'h0000_1001);
        @(negedge clock);
        mem_respValid = 1'b1;
        #1;
        check_val("lck_r0", 32'(lsu_respValid), 1);
        @(negedge clock);
        mem_respValid = 1'b0;
        lsu_addr      = 32'h0000_1004;
        lsu_lock      = 1'b0;
        #1;
        check_val("lck_state", 32'(dut.state), 2);
        check_val("lck_a1", mem_addr, 32'h0000_1004);
        check_val("lck_noifu", 32'(ifu_respValid), 0);
        @(negedge clock);
        mem_respValid = 1'b1;
        #1;
        check_val("lck_r1", 32'(lsu_respValid), 1);
        check_val("lck_r1i", 32'(ifu_respValid), 0);
        @(negedge clock);
        lsu_reqValid  = 1'b0;
        mem_respValid = 1'b0;
        #1;
        check_val("lck_ifu", mem_addr, 32'h8000_0200);

        // Timeout after 8 busy cycles; lock has no effect on the abort.
        do_reset();
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h0000_4000;
        lsu_lock     = 1'b1;
        #1;
        check_val("tmo_issue", 32'(mem_reqValid), 1);
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clock);
            #1;
            check_val($sformatf("tmo_flag%0d", k), 32'(bus_timeout), (k == TMO) ? 1 : 0);
            check_val($sformatf("tmo_resp%0d", k), 32'(lsu_respValid), (k == TMO) ? 1 : 0);
            if (k == TMO) check_val("tmo_req", 32'(mem_reqValid), 0);
        end
        @(negedge clock);
        lsu_reqValid = 1'b0;
        #1;
        check_val("tmo_idle", 32'(dut.state), 0);
        check_val("tmo_flag_off", 32'(bus_timeout), 0);

        // Asynchronous reset in the middle of a BUSY_LSU transaction.
        do_reset();
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h0000_5000;
        @(negedge clock);
        #1;
        check_val("arst_busy", 32'(dut.state), 2);
        #1;
        reset         = 1'b1;
        mem_respValid = 1'b1;
        mem_rdata     = 32'h1111_2222;
        #1;
        check_val("arst_req", 32'(mem_reqValid), 0);
        check_val("arst_resp", 32'(lsu_respValid), 0);
        check_val("arst_addr", mem_addr, 0);
        check_val("arst_rdata", lsu_rdata, 0);
        @(negedge clock);
        idle_inputs();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_val("arst_state", 32'(dut.state), 0);
        check_val("arst_stv", 32'(dut.starve_cnt), 0);
        check_val("arst_tmo", dut.tmo_cnt, 0);

        // Randomized traffic against the reference model.
        do_reset();
        m_owner      = 0;
        m_starve     = 0;
        m_wait       = 0;
        p_ifu_done   = 1'b0;
        p_lsu_done   = 1'b0;
        p_lsu_locked = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            if (!ifu_reqValid) begin
                if ($urandom_range(0, 99) < 40) begin
                    ifu_reqValid = 1'b1;
                    ifu_addr     = $urandom;
                end
            end else if (p_ifu_done) begin
                if ($urandom_range(0, 1) == 0) ifu_reqValid = 1'b0;
                else ifu_addr = $urandom;
            end
            if (!lsu_reqValid) begin
                if ($urandom_range(0, 99) < 40) begin
                    lsu_reqValid = 1'b1;
                    new_lsu();
                end
            end else if (p_lsu_done) begin
                if (!p_lsu_locked && $urandom_range(0, 1) == 0) lsu_reqValid = 1'b0;
                else new_lsu();
            end
            mem_respValid = ($urandom_range(0, 99) < 30);
            mem_rdata     = $urandom;
            #1;

            // Who is served this cycle.
            if (m_owner == 0) begin
                if (lsu_reqValid && !(ifu_reqValid && m_starve == SL)) who = 2;
                else if (ifu_reqValid) who = 1;
                else who = 0;
                want = (who != 0);
            end else begin
                who  = m_owner;
                want = (who == 1) ? ifu_reqValid : lsu_reqValid;
            end
            timeout  = (m_owner != 0) && !mem_respValid && (m_wait == TMO - 1);
            finished = timeout || (mem_respValid && (m_owner != 0 || want));
            locked   = finished && !timeout && (who == 2) && lsu_lock;
            e_mreq   = want && !timeout;
            if (who == 1) begin
                e_addr = ifu_addr; e_wdata = 0; e_size = 2'b10; e_wen = 0; e_wmask = 4'hF;
            end else begin
                e_addr = lsu_addr; e_wdata = lsu_wdata; e_size = lsu_size;
                e_wen = lsu_wen; e_wmask = lsu_wmask;
            end

            check_val("rnd_mreq", 32'(mem_reqValid), 32'(e_mreq));
            if (e_mreq) begin
                check_val("rnd_addr", mem_addr, e_addr);
                check_val("rnd_wdata", mem_wdata, e_wdata);
                check_val("rnd_ctl", {25'd0, mem_size, mem_wen, mem_wmask},
                          {25'd0, e_size, e_wen, e_wmask});
            end
            check_val("rnd_iresp", 32'(ifu_respValid), 32'(finished && who == 1));
            check_val("rnd_lresp", 32'(lsu_respValid), 32'(finished && who == 2));
            check_val("rnd_tmo", 32'(bus_timeout), 32'(timeout));
            check_val("rnd_irdata", ifu_rdata, mem_rdata);
            check_val("rnd_lrdata", lsu_rdata, mem_rdata);

            // Advance the model to the state after the coming clock edge.
            if (finished && !locked) begin
                if (who == 2 && ifu_reqValid) m_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
                else m_starve = 0;
            end
            m_wait = (m_owner != 0 && !mem_respValid && !timeout) ? m_wait + 1 : 0;
            if (finished) m_owner = locked ? 2 : 0;
            else if (m_owner == 0) m_owner = who;
            p_ifu_done   = finished && who == 1;
            p_lsu_done   = finished && who == 2;
            p_lsu_locked = locked;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
